// File: rtl/loader_pkg.sv
// Shared types and constants for the debug program loader: FSM state encoding
// and the host byte-stream framing constants.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    COLLECT,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } loader_state_t;

  localparam int BYTES_PER_INSTR = 4;
  localparam int COUNT_WIDTH     = 16;
  localparam int INSTR_BITS      = 8 * BYTES_PER_INSTR;
  localparam int BYTE_IDX_W      = $clog2(BYTES_PER_INSTR);

  // States in which the loader is willing to take a host byte.
  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == COLLECT);
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects host bytes into one little-endian instruction word; word_valid
// fires combinationally on the cycle the final byte is accepted.
module byte_assembler
  import loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  word_valid,
  output logic [INSTR_BITS-1:0] word
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_INSTR - 1);

  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [INSTR_BITS-1:0] shift_q, shift_d;

  // Byte k of the word lands in lane k, so the completed word is the next-state value.
  for (genvar gi = 0; gi < BYTES_PER_INSTR; gi++) begin : g_lane
    assign shift_d[8*gi +: 8] = (in_valid && (byte_idx_q == BYTE_IDX_W'(gi)))
                                ? in_byte : shift_q[8*gi +: 8];
  end

  always_comb begin
    byte_idx_d = byte_idx_q;
    if (clear) begin
      byte_idx_d = '0;
    end else if (in_valid) begin
      byte_idx_d = (byte_idx_q == LAST_IDX) ? '0 : byte_idx_q + BYTE_IDX_W'(1);
    end
  end

  assign word_valid = in_valid && (byte_idx_q == LAST_IDX);
  assign word       = shift_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx_q <= '0;
      shift_q    <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/debug_program_loader.sv
// Boot-time loader: turns a host byte stream (count + instructions) into timed
// writes on cpuCore's debug instruction port, holding the core in reset meanwhile.
module debug_program_loader
  import loader_pkg::*;
#(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN / 2,
  parameter int SETUP_CYCLES       = 2,
  parameter int STROBE_CYCLES      = 1,
  parameter int HOLD_CYCLES        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  output logic                          byte_ready,
  output logic                          dbg_wr_en,
  output logic [XLEN-1:0]               dbg_addr,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
  output logic                          core_rst,
  output logic                          busy,
  output logic                          done
);

  localparam int TIMER_W = 8;
  localparam logic [TIMER_W-1:0] SETUP_LAST  = TIMER_W'(SETUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STROBE_LAST = TIMER_W'(STROBE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);

  loader_state_t                 state_q, state_d;
  logic [TIMER_W-1:0]            timer_q, timer_d;
  logic [COUNT_WIDTH-1:0]        remaining_q, remaining_d;
  logic [XLEN-1:0]               addr_q, addr_d;
  logic [INSTRUCTION_LENGTH-1:0] instr_q, instr_d;
  logic                          byte_ready_q, byte_ready_d;
  logic                          wr_en_q, wr_en_d;
  logic                          core_rst_q, core_rst_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic                          byte_fire;
  logic                          asm_in_valid;
  logic                          asm_clear;
  logic                          asm_word_valid;
  logic [INSTR_BITS-1:0]         asm_word;

  assign byte_fire    = byte_valid && byte_ready_q;
  assign asm_in_valid = byte_fire && (state_q == COLLECT);
  // Every session passes LEN_HI, so the byte lane index always starts fresh.
  assign asm_clear    = (state_q == LEN_HI);

  byte_assembler u_byte_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .in_valid   (asm_in_valid),
    .in_byte    (byte_data),
    .word_valid (asm_word_valid),
    .word       (asm_word)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    instr_d     = instr_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          state_d     = LEN_LO;
          addr_d      = '0;
          remaining_d = '0;
        end
      end
      LEN_LO: begin
        if (byte_fire) begin
          remaining_d[7:0] = byte_data;
          state_d          = LEN_HI;
        end
      end
      LEN_HI: begin
        if (byte_fire) begin
          remaining_d[COUNT_WIDTH-1:8] = byte_data;
          state_d = ({byte_data, remaining_q[7:0]} == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (asm_word_valid) begin
          instr_d = INSTRUCTION_LENGTH'(asm_word);
          timer_d = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (timer_q == SETUP_LAST) begin
          timer_d = '0;
          state_d = STROBE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      STROBE: begin
        if (timer_q == STROBE_LAST) begin
          timer_d = '0;
          state_d = HOLD;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      HOLD: begin
        if (timer_q == HOLD_LAST) begin
          timer_d = '0;
          if (remaining_q == COUNT_WIDTH'(1)) begin
            state_d = DONE;
          end else begin
            addr_d      = addr_q + XLEN'(1);
            remaining_d = remaining_q - COUNT_WIDTH'(1);
            state_d     = COLLECT;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned with state_q.
    byte_ready_d = accepts_bytes(state_d);
    wr_en_d      = (state_d == STROBE);
    core_rst_d   = (state_d != DONE);
    busy_d       = (state_d != IDLE) && (state_d != DONE);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      remaining_q  <= '0;
      addr_q       <= '0;
      instr_q      <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      core_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      remaining_q  <= remaining_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      core_rst_q   <= core_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign dbg_wr_en  = wr_en_q;
  assign dbg_addr   = addr_q;
  assign dbg_instr  = instr_q;
  assign core_rst   = core_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_debug_program_loader.sv
// Scoreboard bench for debug_program_loader: two instances (default timing and a
// 1/3/2 setup/strobe/hold sweep), one write-monitor per instance.
`timescale 1ns/1ps
module tb_debug_program_loader;

  typedef struct packed {
    logic        inst;
    logic [63:0] addr;
    logic [31:0] instr;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start [2];
  logic        byte_valid [2];
  logic [7:0]  byte_data  [2];
  logic        byte_ready [2];
  logic        dbg_wr_en  [2];
  logic [63:0] dbg_addr   [2];
  logic [31:0] dbg_instr  [2];
  logic        core_rst   [2];
  logic        busy       [2];
  logic        done       [2];

  int          total  = 0;
  int          passed = 0;
  wr_t         exp_q[$];
  logic [7:0]  stream [64];
  int          stream_len;
  logic [31:0] img [8];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int S  = (gi == 0) ? 2 : 1;
    localparam int ST = (gi == 0) ? 1 : 3;
    localparam int H  = (gi == 0) ? 1 : 2;

    debug_program_loader #(
      .XLEN(64), .INSTRUCTION_LENGTH(32),
      .SETUP_CYCLES(S), .STROBE_CYCLES(ST), .HOLD_CYCLES(H)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start[gi]),
      .byte_valid (byte_valid[gi]),
      .byte_data  (byte_data[gi]),
      .byte_ready (byte_ready[gi]),
      .dbg_wr_en  (dbg_wr_en[gi]),
      .dbg_addr   (dbg_addr[gi]),
      .dbg_instr  (dbg_instr[gi]),
      .core_rst   (core_rst[gi]),
      .busy       (busy[gi]),
      .done       (done[gi])
    );

    // phase 0: before a strobe, 1: strobe high, 2: hold after strobe
    int          phase    = 0;
    int          pre_cnt  = 0;
    int          hi_cnt   = 0;
    int          hold_cnt = 0;
    bit          stab_bad = 0;
    logic [63:0] la = '0;
    logic [31:0] li = '0;
    wr_t         e;

    always @(negedge clk or negedge rst) begin
      if (!rst) begin
        phase = 0; pre_cnt = 0; hi_cnt = 0; hold_cnt = 0; stab_bad = 0;
      end else begin
        if (phase == 0) begin
          if (dbg_wr_en[gi]) begin
            check($sformatf("setup_len[%0d]", gi), 64'(pre_cnt), 64'(S));
            check($sformatf("write_expected[%0d]", gi), 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check($sformatf("wr_inst[%0d]", gi), 64'(e.inst), 64'(gi));
              check($sformatf("wr_addr[%0d]", gi), dbg_addr[gi], e.addr);
              check($sformatf("wr_instr[%0d]", gi), 64'(dbg_instr[gi]), 64'(e.instr));
              $display("write inst=%0d addr=%0d instr=0x%08h", gi, dbg_addr[gi], dbg_instr[gi]);
            end
            la = dbg_addr[gi]; li = dbg_instr[gi];
            phase = 1; hi_cnt = 0; stab_bad = 0;
          end else begin
            if (busy[gi] && !byte_ready[gi] && !done[gi]) begin
              if (dbg_addr[gi] != la || dbg_instr[gi] != li) pre_cnt = 1;
              else pre_cnt++;
            end else begin
              pre_cnt = 0;
            end
            la = dbg_addr[gi]; li = dbg_instr[gi];
          end
        end
        if (phase == 1) begin
          if (dbg_wr_en[gi]) begin
            hi_cnt++;
            if (dbg_addr[gi] != la || dbg_instr[gi] != li) stab_bad = 1;
          end else begin
            check($sformatf("strobe_len[%0d]", gi), 64'(hi_cnt), 64'(ST));
            check($sformatf("strobe_stable[%0d]", gi), 64'(stab_bad), 64'd0);
            phase = 2; hold_cnt = 0;
          end
        end
        if (phase == 2) begin
          if (!dbg_wr_en[gi] && busy[gi] && !byte_ready[gi] && !done[gi] &&
              dbg_addr[gi] == la && dbg_instr[gi] == li) begin
            hold_cnt++;
          end else begin
            check($sformatf("hold_len[%0d]", gi), 64'(hold_cnt), 64'(H));
            phase = 0; pre_cnt = 0;
          end
        end
      end
    end
  end

  task automatic pulse_start(input int idx);
    load_start[idx] = 1'b1;
    @(posedge clk); #1;
    load_start[idx] = 1'b0;
  endtask

  task automatic send_byte(input int idx, input logic [7:0] b, input bit stall);
    int tries = 0;
    bit acc = 0;
    while (!acc && tries <= 100) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        byte_valid[idx] = 1'b0;
        byte_data[idx]  = 8'($urandom);
      end else begin
        byte_valid[idx] = 1'b1;
        byte_data[idx]  = b;
      end
      @(negedge clk);
      acc = byte_valid[idx] && byte_ready[idx];
      @(posedge clk); #1;
      tries++;
    end
    if (!acc) check("byte_accept_timeout", 64'd0, 64'd1);
    byte_valid[idx] = 1'b0;
  endtask

  task automatic send_range(input int idx, input int from, input int to, input bit stall);
    for (int i = from; i < to; i++) send_byte(idx, stream[i], stall);
  endtask

  task automatic build_stream(input int n);
    logic [15:0] cnt = 16'(n);
    logic [31:0] w;
    stream[0] = cnt[7:0];
    stream[1] = cnt[15:8];
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) stream[2 + 4*i + k] = w[8*k +: 8];
    end
    stream_len = 2 + 4*n;
  endtask

  task automatic push_exp(input int idx, input int n);
    wr_t x;
    for (int i = 0; i < n; i++) begin
      x.inst = idx[0]; x.addr = 64'(i); x.instr = img[i];
      exp_q.push_back(x);
    end
  endtask

  task automatic wait_core_rst_low(input int idx, input int exp_n, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (core_rst[idx] !== 1'b0 && n < 60);
    check(name, 64'(n), 64'(exp_n));
    @(posedge clk); #1;
  endtask

  task automatic check_done(input int idx, input logic [63:0] addr_exp, input string tag);
    check({tag, "_done"}, 64'(done[idx]), 64'd1);
    check({tag, "_busy"}, 64'(busy[idx]), 64'd0);
    check({tag, "_core_rst"}, 64'(core_rst[idx]), 64'd0);
    check({tag, "_byte_ready"}, 64'(byte_ready[idx]), 64'd0);
    check({tag, "_addr"}, dbg_addr[idx], addr_exp);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    $display("%s finished inst=%0d addr=%0d", tag, idx, dbg_addr[idx]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_start[i] = 1'b0; byte_valid[i] = 1'b0; byte_data[i] = 8'h00;
    end
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_byte_ready", 64'(byte_ready[i]), 64'd0);
      check("rst_wr_en", 64'(dbg_wr_en[i]), 64'd0);
      check("rst_addr", dbg_addr[i], 64'd0);
      check("rst_instr", 64'(dbg_instr[i]), 64'd0);
      check("rst_core_rst", 64'(core_rst[i]), 64'd1);
      check("rst_busy", 64'(busy[i]), 64'd0);
      check("rst_done", 64'(done[i]), 64'd0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Three-word image from the literal host byte stream.
    stream = '{default: 8'h00};
    {stream[0], stream[1], stream[2], stream[3], stream[4], stream[5], stream[6]} =
      {8'h03, 8'h00, 8'hA3, 8'h37, 8'h50, 8'h00, 8'h0F};
    {stream[7], stream[8], stream[9], stream[10], stream[11], stream[12], stream[13]} =
      {8'h00, 8'h20, 8'h01, 8'h03, 8'h34, 8'h40, 8'h00};
    stream_len = 14;
    img[0] = 32'h005037A3; img[1] = 32'h0120000F; img[2] = 32'h00403403;
    push_exp(0, 3);
    pulse_start(0);
    check("start_busy", 64'(busy[0]), 64'd1);
    check("start_byte_ready", 64'(byte_ready[0]), 64'd1);
    send_range(0, 0, stream_len, 1'b0);
    wait_core_rst_low(0, 5, "load3_core_rst_latency");
    check_done(0, 64'd2, "load3");

    // Reload after DONE with a single word.
    pulse_start(0);
    check("reload_core_rst", 64'(core_rst[0]), 64'd1);
    check("reload_done", 64'(done[0]), 64'd0);
    check("reload_addr_cleared", dbg_addr[0], 64'd0);
    img[0] = 32'h00000013;
    build_stream(1);
    push_exp(0, 1);
    send_range(0, 0, stream_len, 1'b0);
    wait_core_rst_low(0, 5, "reload_core_rst_latency");
    check_done(0, 64'd0, "reload");

    // Empty image.
    pulse_start(0);
    build_stream(0);
    send_range(0, 0, stream_len, 1'b0);
    wait_core_rst_low(0, 1, "count0_core_rst_latency");
    check_done(0, 64'd0, "count0");

    // Host stalls: same image as the first load.
    img[0] = 32'h005037A3; img[1] = 32'h0120000F; img[2] = 32'h00403403;
    build_stream(3);
    push_exp(0, 3);
    pulse_start(0);
    send_range(0, 0, stream_len, 1'b1);
    wait_core_rst_low(0, 5, "stall_core_rst_latency");
    check_done(0, 64'd2, "stall");

    // load_start pulsed mid-load is ignored.
    img[0] = 32'h00000013; img[1] = 32'h00100093;
    build_stream(2);
    push_exp(0, 2);
    pulse_start(0);
    send_range(0, 0, 6, 1'b0);
    pulse_start(0);
    send_range(0, 6, stream_len, 1'b0);
    wait_core_rst_low(0, 5, "midstart_core_rst_latency");
    check_done(0, 64'd1, "midstart");

    // Reset during the strobe of the second instruction.
    img[0] = 32'h005037A3; img[1] = 32'h0120000F; img[2] = 32'h00403403;
    build_stream(3);
    push_exp(0, 2);
    pulse_start(0);
    send_range(0, 0, 10, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dbg_wr_en[0] === 1'b1 && dbg_addr[0] == 64'd1) && n < 20);
    check("strobe2_reached", 64'(n < 20), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_wr_en", 64'(dbg_wr_en[0]), 64'd0);
    check("midrst_core_rst", 64'(core_rst[0]), 64'd1);
    check("midrst_busy", 64'(busy[0]), 64'd0);
    check("midrst_byte_ready", 64'(byte_ready[0]), 64'd0);
    $display("reset asserted during strobe of addr 1");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    img[0] = 32'h00A00513;
    build_stream(1);
    push_exp(0, 1);
    pulse_start(0);
    send_range(0, 0, stream_len, 1'b0);
    wait_core_rst_low(0, 5, "postrst_core_rst_latency");
    check_done(0, 64'd0, "postrst");

    // Timing sweep instance: setup 1, strobe 3, hold 2.
    img[0] = 32'h12345678; img[1] = 32'h9ABCDEF0;
    build_stream(2);
    push_exp(1, 2);
    pulse_start(1);
    send_range(1, 0, stream_len, 1'b0);
    wait_core_rst_low(1, 7, "sweep_core_rst_latency");
    check_done(1, 64'd1, "sweep");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
